// File: rtl/wbs_uart_rx_fifo.sv
// wbs_uart_rx_fifo: UART receiver with status-tagged receive FIFO behind a Wishbone slave
//   wbs_clk_i/wbs_rst_i : clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i/adr_i, wbs_dat_o/ack_o : Wishbone slave (adr 0 DATA, 1 STATUS)
//   irq_uart_rx : high while FIFO holds data
//   uart_rx     : asynchronous serial input, idle high
module wbs_uart_rx_fifo #(
  parameter int TICKS_PER_BAUD = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic        wbs_adr_i,
  output logic [15:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        irq_uart_rx,
  input  logic        uart_rx
);
  localparam int TW = $clog2(TICKS_PER_BAUD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] MID = TW'(TICKS_PER_BAUD / 2);
  localparam logic [TW-1:0] LAST = TW'(TICKS_PER_BAUD - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, hold_q, hold_d, perr_q, perr_d, ovr_q, ovr_d, ack_q, irq_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [15:0] dat_q, dat_d;
  logic [9:0] mem [FIFO_DEPTH];
  logic rx, mid, push, push_ok, req, rd_data, rd_stat, pop, empty, full;
  assign rx = s2_q;
  assign mid = tick_q == MID;
  always_comb begin
    state_d = state_q;
    tick_d = (tick_q == LAST) ? '0 : tick_q + TW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    perr_d = perr_q;
    hold_d = hold_q;
    push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        // after a framing error, wait for the line to be seen high before re-arming
        hold_d = hold_q & !rx;
        state_d = (!rx && !hold_q) ? ST_START : ST_IDLE;
      end
      ST_START: if (mid) begin
        state_d = rx ? ST_IDLE : ST_DATA;
        bit_d = '0;
        sh_d = '0;
        perr_d = 1'b0;
      end
      ST_DATA: if (mid) begin
        sh_d[bit_q] = rx;
        bit_d = bit_q + 3'd1;
        if (bit_q == LAST_BIT) state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: if (mid) begin
        perr_d = (^sh_q) ^ rx ^ (PARITY == 1);
        state_d = ST_STOP;
      end
      ST_STOP: if (mid) begin
        push = 1'b1;
        hold_d = !rx;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign push_ok = push & !full;
  assign req = wbs_cyc_i & wbs_stb_i & !ack_q;
  assign rd_data = req & !wbs_we_i & !wbs_adr_i;
  assign rd_stat = req & !wbs_we_i & wbs_adr_i;
  assign pop = rd_data & !empty;
  assign cnt_d = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
  assign ovr_d = (push & full) | (ovr_q & !rd_stat);
  assign dat_d = rd_data ? (empty ? 16'h0 : {1'b1, 5'b0, mem[rptr_q]}) :
                 rd_stat ? {5'b0, ovr_q, full, empty, 8'(cnt_q)} : dat_q;
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i)
    if (wbs_rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= ST_IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      perr_q <= 1'b0;
      hold_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      s1_q <= uart_rx;
      s2_q <= s1_q;
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      perr_q <= perr_d;
      hold_q <= hold_d;
      wptr_q <= push_ok ? wptr_q + AW'(1) : wptr_q;
      rptr_q <= pop ? rptr_q + AW'(1) : rptr_q;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      ack_q <= req;
      dat_q <= dat_d;
      irq_q <= !empty;
    end
  always_ff @(posedge wbs_clk_i)
    if (push_ok) mem[wptr_q] <= {!rx, perr_q, sh_q};
  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign irq_uart_rx = irq_q;
endmodule

// File: tb/tb_wbs_uart_rx_fifo.sv
// tb_wbs_uart_rx_fifo: directed table-driven bench for wbs_uart_rx_fifo
module tb_wbs_uart_rx_fifo;
  localparam int T = 8;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0, rx = 1'b1;
  logic [15:0] dat;
  logic ack, irq;
  int total = 0, bad = 0;
  logic [15:0] rd;
  typedef struct {
    logic [7:0] d;
    logic p;
    logic s;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [8];

  wbs_uart_rx_fifo #(.TICKS_PER_BAUD(T), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut (
    .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_o(dat), .wbs_ack_o(ack), .irq_uart_rx(irq), .uart_rx(rx));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    cycles(T);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(s);
    rx = 1'b1;
    cycles(4);
  endtask

  task automatic xfer(input logic w, input logic a, output logic [15:0] d);
    logic got;
    d = '0;
    got = 1'b0;
    cycles(1);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a;
    for (int i = 0; i < 4 && !got; i++) begin
      cycles(1);
      if (ack) begin got = 1'b1; d = dat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_seen", {15'b0, got}, 16'h1);
    cycles(1);
    check("ack_one_cycle", {15'b0, ack}, 16'h0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1, 16'h8055};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 16'h8155};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 16'h823C};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 16'h80A5};
    vecs[4] = '{8'h7E, 1'b0, 1'b1, 16'h807E};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 16'h8100};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 16'h80FF};
    vecs[7] = '{8'h0F, 1'b1, 1'b0, 16'h830F};
    cycles(3);
    check("rst_ack", {15'b0, ack}, 16'h0);
    check("rst_dat", dat, 16'h0);
    check("rst_irq", {15'b0, irq}, 16'h0);
    rst = 1'b0;
    cycles(2);
    xfer(1'b0, 1'b1, rd);
    check("rst_status", rd, 16'h0100);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].p, vecs[i].s);
      check($sformatf("v%0d_irq_set", i), {15'b0, irq}, 16'h1);
      xfer(1'b0, 1'b0, rd);
      check($sformatf("v%0d_data", i), rd, vecs[i].exp);
      check($sformatf("v%0d_irq_clr", i), {15'b0, irq}, 16'h0);
    end
    xfer(1'b0, 1'b1, rd);
    check("status_after_reads", rd, 16'h0100);

    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send(b, ^b, 1'b1);
    end
    check("ovr_irq", {15'b0, irq}, 16'h1);
    xfer(1'b0, 1'b1, rd);
    check("ovr_status", rd, 16'h0604);
    for (int i = 1; i <= 4; i++) begin
      xfer(1'b0, 1'b0, rd);
      check($sformatf("ovr_data%0d", i), rd, 16'h8000 | 16'(i));
    end
    xfer(1'b0, 1'b1, rd);
    check("ovr_cleared", rd, 16'h0100);

    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(4 * T);
    check("glitch_irq", {15'b0, irq}, 16'h0);
    xfer(1'b0, 1'b1, rd);
    check("glitch_status", rd, 16'h0100);
    send(8'hA5, 1'b0, 1'b1);
    xfer(1'b0, 1'b0, rd);
    check("glitch_next", rd, 16'h80A5);

    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(i == 0 ? 1'b0 : 1'b1);
    rx = 1'b1;
    cycles(T / 2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midrst_ack", {15'b0, ack}, 16'h0);
    check("midrst_irq", {15'b0, irq}, 16'h0);
    cycles(12 * T);
    check("midrst_irq_late", {15'b0, irq}, 16'h0);
    xfer(1'b0, 1'b1, rd);
    check("midrst_status", rd, 16'h0100);
    send(8'h7E, 1'b0, 1'b1);
    xfer(1'b0, 1'b0, rd);
    check("midrst_next", rd, 16'h807E);

    xfer(1'b0, 1'b0, rd);
    check("empty_read", rd, 16'h0000);
    xfer(1'b1, 1'b0, rd);
    xfer(1'b0, 1'b1, rd);
    check("write_ignored", rd, 16'h0100);
    cyc = 1'b1; stb = 1'b1; adr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check($sformatf("held_ack%0d", i), {15'b0, ack}, (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
